// File: rtl/counter_down_reload.sv
// Loadable down-counter with valid/ready load, borrow-out and optional auto-reload.
// Counts load_val..0 on enabled cycles, then idles (done pulse) or reloads.
module counter_down_reload #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [DW-1:0] load_val,
   input  logic          load_auto,
   input  logic          en,
   input  logic          abort,
   output logic [DW-1:0] cnt,
   output logic          busy,
   output logic          bo,
   output logic          done
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [DW-1:0] r_cnt;
   logic [DW-1:0] w_cnt_nxt;
   logic [DW-1:0] r_reload;
   logic [DW-1:0] w_reload_nxt;
   logic          r_auto;
   logic          w_auto_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          w_zero;
   logic          w_term;

   assign w_zero     = (r_cnt == '0);
   // Terminal cycle is cancelled by abort or reset.
   assign w_term     = (r_state == S_RUN) & en & w_zero & ~abort & ~rst;
   assign load_ready = (r_state == S_IDLE) & ~abort & ~rst;
   assign cnt        = r_cnt;
   assign busy       = (r_state == S_RUN);
   assign bo         = w_term;
   assign done       = r_done;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_reload_nxt = r_reload;
      w_auto_nxt   = r_auto;
      w_done_nxt   = 1'b0;
      if (abort) begin
         if (r_state == S_RUN) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (load_valid) begin
                  w_state_nxt  = S_RUN;
                  w_cnt_nxt    = load_val;
                  w_reload_nxt = load_val;
                  w_auto_nxt   = load_auto;
               end
            end
            S_RUN: begin
               if (en) begin
                  if (!w_zero) begin
                     w_cnt_nxt = r_cnt - 1'b1;
                  end else if (r_auto) begin
                     w_cnt_nxt = r_reload;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_reload <= '0;
         r_auto   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_reload <= w_reload_nxt;
         r_auto   <= w_auto_nxt;
         r_done   <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_counter_down_reload.sv
// Directed table-driven bench for counter_down_reload (DW=8).
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_counter_down_reload;

   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_val;
   logic          load_auto;
   logic          en;
   logic          abort;
   logic [DW-1:0] cnt;
   logic          busy;
   logic          bo;
   logic          done;

   int n_checks;
   int n_errors;

   typedef struct {
      logic          rst;
      logic          lv;
      logic [DW-1:0] val;
      logic          auto_;
      logic          en;
      logic          ab;
      logic [DW-1:0] e_cnt;
      logic          e_busy;
      logic          e_bo;
      logic          e_done;
      logic          e_lr;
   } vec_t;

   vec_t vecs[$];

   counter_down_reload #(.DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_val   (load_val),
      .load_auto  (load_auto),
      .en         (en),
      .abort      (abort),
      .cnt        (cnt),
      .busy       (busy),
      .bo         (bo),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic lv, input int val,
                      input logic au, input logic e, input logic ab,
                      input int ec, input logic eb, input logic ebo,
                      input logic ed, input logic elr);
      vec_t v;
      v.rst = r; v.lv = lv; v.val = val[DW-1:0]; v.auto_ = au;
      v.en = e; v.ab = ab; v.e_cnt = ec[DW-1:0]; v.e_busy = eb;
      v.e_bo = ebo; v.e_done = ed; v.e_lr = elr;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic lv, input int val,
                        input logic au, input logic e, input logic ab);
      @(posedge clk);
      #1;
      rst = r; load_valid = lv; load_val = val[DW-1:0];
      load_auto = au; en = e; abort = ab;
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; load_valid = 1'b0; load_val = '0;
      load_auto = 1'b0; en = 1'b0; abort = 1'b0;

      //  rst lv val au en ab | cnt busy bo done lr
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // one-shot load 3
      add(0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,   3, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   2, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // auto-reload load 2
      add(0, 1, 2, 1, 0, 0,   0, 0, 0, 0, 1);
      for (int k = 0; k < 9; k++)
         add(0, 0, 0, 0, 1, 0, 2 - (k % 3), 1, (k % 3) == 2, 0, 0);
      add(0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // en gaps, then reload in the done cycle
      add(0, 1, 2, 0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0,   2, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0);
      add(0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
      // abort on terminal cycle
      add(0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // load_valid held in RUN is ignored
      add(0, 1, 4, 0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 1, 5, 1, 0, 0,   4, 1, 0, 0, 0);
      add(0, 1, 5, 1, 1, 0,   4, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
      // abort in RUN, then abort + load in IDLE drops the load
      add(0, 0, 0, 0, 0, 1,   3, 1, 0, 0, 0);
      add(0, 1, 7, 0, 0, 1,   0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // load 0
      add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].lv, int'(vecs[i].val),
               vecs[i].auto_, vecs[i].en, vecs[i].ab);
         chk($sformatf("v%0d cnt", i), int'(cnt), int'(vecs[i].e_cnt));
         chk($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].e_busy));
         chk($sformatf("v%0d bo", i), int'(bo), int'(vecs[i].e_bo));
         chk($sformatf("v%0d done", i), int'(done), int'(vecs[i].e_done));
         chk($sformatf("v%0d load_ready", i), int'(load_ready),
             int'(vecs[i].e_lr));
      end

      // full range: 255 -> 0 takes 256 enabled cycles, bo only on the last
      drive(0, 1, 255, 0, 0, 0);
      for (int i = 0; i < 256; i++) begin
         drive(0, 0, 0, 0, 1, 0);
         chk($sformatf("full cnt%0d", i), int'(cnt), 255 - i);
         chk($sformatf("full bo%0d", i), int'(bo), int'(i == 255));
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("full end cnt", int'(cnt), 0);
      chk("full end busy", int'(busy), 0);
      chk("full end done", int'(done), 1);

      // reset mid-run at cnt=100
      drive(0, 1, 200, 1, 0, 0);
      for (int i = 0; i < 100; i++) drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("mid cnt", int'(cnt), 100);
      chk("mid busy", int'(busy), 1);
      drive(1, 1, 9, 0, 1, 0);
      chk("rst load_ready", int'(load_ready), 0);
      chk("rst bo", int'(bo), 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("post-rst cnt", int'(cnt), 0);
      chk("post-rst busy", int'(busy), 0);
      chk("post-rst done", int'(done), 0);
      chk("post-rst load_ready", int'(load_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
